regfile_param: RTL and testbench
================================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter REG_WIDTH, default 8: bits per register and per data port.
REQ-002 SHALL have parameter NUM_REGS, default 8: register count, range 2..32, power of two not required.
REQ-003 SHALL have parameter NUM_RD, default 2: number of independent read ports.
REQ-004 SHALL have parameter NUM_IMM, default 4: number of entries in the immediate table.
REQ-005 SHALL have port Clk, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port Rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port Start, input, 1: request re-initialisation sweep.
REQ-008 SHALL have port WenR, input, 1: ALU write enable.
REQ-009 SHALL have port Ldr, input, 1: load write enable, data from Rdat.
REQ-010 SHALL have port Wd, input, AW = clog2(NUM_REGS): write address.
REQ-011 SHALL have ports WdatR and Rdat, input, REG_WIDTH each: ALU write data and load write data.
REQ-012 SHALL have ports Ra, input, NUM_RD x AW: read address per port.
REQ-013 SHALL have ports UseImm, input, NUM_RD x 1: per-port immediate select.
REQ-014 SHALL have port ImmSel, input, clog2(NUM_IMM): immediate table index, shared by all ports.
REQ-015 SHALL have ports Rdat_o, output, NUM_RD x REG_WIDTH: read data per port.
REQ-016 SHALL have port RLast, output, REG_WIDTH: registers[NUM_REGS-1], always visible.
REQ-017 SHALL have port Busy, output, 1: high while the init sweep runs.
REQ-018 SHALL have port WrCollide, output, 1: one-cycle pulse on a same-cycle WenR/Ldr write.

Function
REQ-019 SHALL have FSM states IDLE, SWEEP, READY.
REQ-020 SHALL stay in IDLE after reset, with writes blocked, until Start.
REQ-021 SHALL move IDLE/READY -> SWEEP on Start, with sweep index = 0.
REQ-022 SHALL, in SWEEP, write RESET_VAL[idx] into registers[idx] each cycle, idx incrementing by 1.
REQ-023 SHALL move SWEEP -> READY in the cycle after idx = NUM_REGS-1 is written; sweep takes exactly NUM_REGS cycles.
REQ-024 SHALL restart the sweep at idx = 0 when Start is asserted during SWEEP.
REQ-025 SHALL hold Busy = 1 in SWEEP and in IDLE, and Busy = 0 in READY only.
REQ-026 SHALL ignore WenR and Ldr while Busy = 1; no register changes except sweep writes, and WrCollide stays 0.
REQ-027 SHALL, in READY with Ldr = 1, write Rdat to registers[Wd]; Ldr has priority over WenR.
REQ-028 SHALL, in READY with WenR = 1 and Ldr = 0, write WdatR to registers[Wd].
REQ-029 SHALL pulse WrCollide for the next cycle when WenR and Ldr are both 1 in READY; Rdat wins.
REQ-030 SHALL ignore writes with Wd >= NUM_REGS, with no state change.
REQ-031 SHALL make read combinational: Rdat_o[p] = UseImm[p] ? IMM_TABLE[ImmSel] : registers[Ra[p]].
REQ-032 SHALL return 0 for a read of Ra >= NUM_REGS, and for ImmSel >= NUM_IMM.
REQ-033 SHALL make write-to-read latency 1 cycle: new data is visible the cycle after the write edge (bypass off).

Reset
REQ-034 SHALL, on Rst_n low, immediately load registers with RESET_VAL, set FSM = IDLE, idx = 0, and WrCollide = 0.
REQ-035 SHALL abort a sweep or write in progress on reset mid-operation; no partial state survives.
REQ-036 SHALL have outputs at reset: Busy = 1, WrCollide = 0, RLast = RESET_VAL[NUM_REGS-1], and Rdat_o per REQ-031.

Configuration
REQ-037 SHALL use macro REGFILE_BYPASS_EN: when defined, a read port whose Ra equals Wd of an accepted write in the same cycle returns that cycle's write data (Rdat if Ldr, else WdatR); the same applies to RLast.
REQ-038 SHALL, without REGFILE_BYPASS_EN, return pre-write contents on such reads, with no forwarding logic.

Structure
REQ-039 SHALL place in package regfile_pkg: the FSM state enum, RESET_VAL function (entry 2 = 16, others 0), and IMM_TABLE localparam (66, 67, 60, 0).
REQ-040 SHALL implement the sweep FSM and index counter as sub-module regfile_init_seq (outputs Busy, sweep write enable, sweep index).

Verification
REQ-041 SHALL check reset then Start: Busy = 1 for 8 cycles, then 0; registers[2] = 16, others 0.
REQ-042 SHALL check, in READY, WenR = 1, Wd = 5, WdatR = 0xA5: next cycle, Ra[0] = 5 gives 0xA5; with bypass on, Rdat_o = 0xA5 in the same cycle.
REQ-043 SHALL check WenR = Ldr = 1, Wd = 3, WdatR = 0x11, Rdat = 0x22: registers[3] = 0x22 and WrCollide pulses once.
REQ-044 SHALL check Start reasserted at sweep cycle 4 after register 7 was set to 0x55: the sweep restarts and Busy lasts 8 more cycles; RLast ends at 0.
REQ-045 SHALL check UseImm[1] = 1, ImmSel = 1: Rdat_o[1] = 67 while Rdat_o[0] reads its register normally.
REQ-046 SHALL check Rst_n low mid-sweep: Busy = 1, FSM = IDLE, RESET_VAL restored within the same cycle, with no clock edge required.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: sweep FSM states,
// per-register reset values and the read-port immediate table.
package regfile_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        READY = 2'd2
    } state_e;

    localparam int IMM_COUNT = 4;
    localparam int IMM_TABLE [IMM_COUNT] = '{66, 67, 60, 0};

    // Value a register takes on reset and during an init sweep.
    function automatic int RESET_VAL(input int idx);
        return (idx == 2) ? 16 : 0;
    endfunction

endpackage

// File: rtl/regfile_init_seq.sv
// Init sweep sequencer: walks the register index from 0 to NUM_REGS-1 after
// Start, raising a sweep write enable for each index, then settles in READY.
// Busy stays high until the first sweep completes and during every sweep.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int AW       = 3
)(
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          Start,
    output logic          Busy,
    output logic          SweepWe,
    output logic [AW-1:0] SweepIdx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);

    state_e        state_q;
    logic          busy_q;
    logic          sweepWe_q;
    logic [AW-1:0] idx_q;

    // Sweep FSM with registered Busy / write-enable / index outputs.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            busy_q    <= 1'b1;
            sweepWe_q <= 1'b0;
            idx_q     <= '0;
        end else begin
            case (state_q)
                IDLE, READY: begin
                    if (Start) begin
                        state_q   <= SWEEP;
                        busy_q    <= 1'b1;
                        sweepWe_q <= 1'b1;
                        idx_q     <= '0;
                    end
                end
                SWEEP: begin
                    if (Start) begin
                        idx_q <= '0;
                    end else if (idx_q == LAST_IDX) begin
                        state_q   <= READY;
                        busy_q    <= 1'b0;
                        sweepWe_q <= 1'b0;
                        idx_q     <= '0;
                    end else begin
                        idx_q <= idx_q + AW'(1);
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b1;
                    sweepWe_q <= 1'b0;
                    idx_q     <= '0;
                end
            endcase
        end
    end

    assign Busy     = busy_q;
    assign SweepWe  = sweepWe_q;
    assign SweepIdx = idx_q;

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file with an init sweep, one write port (ALU or load
// data, load wins), NUM_RD combinational read ports with an immediate-table
// select, and a one-cycle collision pulse when both write sources fire.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module regfile_param
    import regfile_pkg::*;
#(
    parameter int REG_WIDTH = 8,
    parameter int NUM_REGS  = 8,
    parameter int NUM_RD    = 2,
    parameter int NUM_IMM   = 4,
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1,
    localparam int IW = (NUM_IMM > 1) ? $clog2(NUM_IMM) : 1
)(
    input  logic                             Clk,
    input  logic                             Rst_n,
    input  logic                             Start,
    input  logic                             WenR,
    input  logic                             Ldr,
    input  logic [AW-1:0]                    Wd,
    input  logic [REG_WIDTH-1:0]             WdatR,
    input  logic [REG_WIDTH-1:0]             Rdat,
    input  logic [NUM_RD-1:0][AW-1:0]        Ra,
    input  logic [NUM_RD-1:0]                UseImm,
    input  logic [IW-1:0]                    ImmSel,
    output logic [NUM_RD-1:0][REG_WIDTH-1:0] Rdat_o,
    output logic [REG_WIDTH-1:0]             RLast,
    output logic                             Busy,
    output logic                             WrCollide
);

    localparam int             IMM_LIM   = (NUM_IMM < IMM_COUNT) ? NUM_IMM : IMM_COUNT;
    localparam logic [AW:0]    REG_LIMIT = (AW+1)'(NUM_REGS);
    localparam logic [IW:0]    IMM_LIMIT = (IW+1)'(IMM_LIM);
    localparam logic [AW-1:0]  LAST_REG  = AW'(NUM_REGS - 1);

    logic [REG_WIDTH-1:0] regs_q [NUM_REGS];
    logic [REG_WIDTH-1:0] regs_d [NUM_REGS];
    logic                 wrCollide_q;
    logic                 wrCollide_d;
    logic                 sweepWe;
    logic [AW-1:0]        sweepIdx;
    logic                 wrAccept;
    logic [REG_WIDTH-1:0] wrData;
    logic [REG_WIDTH-1:0] immData;

    regfile_init_seq #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW)
    ) u_init_seq (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .Start    (Start),
        .Busy     (Busy),
        .SweepWe  (sweepWe),
        .SweepIdx (sweepIdx)
    );

    // Writes only land once the file is READY and the address is in range.
    assign wrAccept    = !Busy && (WenR || Ldr) && ({1'b0, Wd} < REG_LIMIT);
    assign wrData      = Ldr ? Rdat : WdatR;
    assign wrCollide_d = !Busy && WenR && Ldr;

    // Next register contents: sweep writes and port writes never overlap.
    always_comb begin
        regs_d = regs_q;
        if (sweepWe) begin
            regs_d[sweepIdx] = REG_WIDTH'(RESET_VAL(int'(sweepIdx)));
        end else if (wrAccept) begin
            regs_d[Wd] = wrData;
        end
    end

    // Register storage and collision flag, both restored immediately on reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= REG_WIDTH'(RESET_VAL(i));
            end
            wrCollide_q <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            wrCollide_q <= wrCollide_d;
        end
    end

    assign WrCollide = wrCollide_q;

    // Immediate lookup shared by every read port; out-of-table selects read 0.
    always_comb begin
        immData = '0;
        if ({1'b0, ImmSel} < IMM_LIMIT) begin
            immData = REG_WIDTH'(IMM_TABLE[ImmSel]);
        end
    end

    // Combinational read ports; out-of-range addresses read 0.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            Rdat_o[p] = '0;
            if (UseImm[p]) begin
                Rdat_o[p] = immData;
            end else if ({1'b0, Ra[p]} < REG_LIMIT) begin
`ifdef REGFILE_BYPASS_EN
                if (wrAccept && (Ra[p] == Wd)) begin
                    Rdat_o[p] = wrData;
                end else begin
                    Rdat_o[p] = regs_q[Ra[p]];
                end
`else
                Rdat_o[p] = regs_q[Ra[p]];
`endif
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign RLast = (wrAccept && (Wd == LAST_REG)) ? wrData : regs_q[NUM_REGS-1];
`else
    assign RLast = regs_q[NUM_REGS-1];
`endif

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param (default parameters). Directed
// sequences cover reset, sweep length, write latency, collisions, sweep
// restart and mid-sweep reset; a read table covers the immediate path; a
// random phase is compared against a behavioural model of the register file.
module tb_regfile_param;

    localparam int NR = 8;

    logic            clk = 1'b0;
    logic            rstN;
    logic            start;
    logic            wenR;
    logic            ldr;
    logic [2:0]      wd;
    logic [7:0]      wdatR;
    logic [7:0]      rdat;
    logic [1:0][2:0] ra;
    logic [1:0]      useImm;
    logic [1:0]      immSel;
    logic [1:0][7:0] rdatO;
    logic [7:0]      rLast;
    logic            busy;
    logic            wrCollide;

    int compared   = 0;
    int mismatched = 0;

    int mRegs [NR];
    int mSweep;
    bit mReady;
    bit mCollide;

    typedef struct {
        int         ra0;
        int         ra1;
        logic [1:0] useI;
        int         sel;
        int         exp0;
        int         exp1;
    } rdVec_t;

    rdVec_t vecs [6];

    always #5 clk = ~clk;

    regfile_param dut (
        .Clk       (clk),
        .Rst_n     (rstN),
        .Start     (start),
        .WenR      (wenR),
        .Ldr       (ldr),
        .Wd        (wd),
        .WdatR     (wdatR),
        .Rdat      (rdat),
        .Ra        (ra),
        .UseImm    (useImm),
        .ImmSel    (immSel),
        .Rdat_o    (rdatO),
        .RLast     (rLast),
        .Busy      (busy),
        .WrCollide (wrCollide)
    );

    function automatic int rv(input int i);
        return (i == 2) ? 16 : 0;
    endfunction

    function automatic int immVal(input int s);
        case (s)
            0:       return 66;
            1:       return 67;
            2:       return 60;
            default: return 0;
        endcase
    endfunction

    function automatic bit wrAcc();
        return mReady && (wenR || ldr) && (int'(wd) < NR);
    endfunction

    function automatic int wrVal();
        return ldr ? int'(rdat) : int'(wdatR);
    endfunction

    function automatic int expRead(input int p);
        if (useImm[p]) return immVal(int'(immSel));
        if (int'(ra[p]) >= NR) return 0;
`ifdef REGFILE_BYPASS_EN
        if (wrAcc() && (ra[p] == wd)) return wrVal();
`endif
        return mRegs[ra[p]];
    endfunction

    function automatic int expLast();
`ifdef REGFILE_BYPASS_EN
        if (wrAcc() && (int'(wd) == NR - 1)) return wrVal();
`endif
        return mRegs[NR-1];
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NR; i++) mRegs[i] = rv(i);
        mSweep   = -1;
        mReady   = 1'b0;
        mCollide = 1'b0;
    endtask

    // One rising edge of the reference: sweep position, ready flag, contents.
    task automatic modelEdge();
        bit wasReady;
        wasReady = mReady;
        mCollide = wasReady && wenR && ldr;
        if (mSweep >= 0) begin
            mRegs[mSweep] = rv(mSweep);
            if (start) mSweep = 0;
            else if (mSweep == NR - 1) begin
                mSweep = -1;
                mReady = 1'b1;
            end else mSweep = mSweep + 1;
        end else begin
            if (wrAcc()) mRegs[wd] = wrVal();
            if (start) begin
                mSweep = 0;
                mReady = 1'b0;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        cmp({tag, "/busy"},  {31'b0, busy},      {31'b0, !mReady});
        cmp({tag, "/coll"},  {31'b0, wrCollide}, {31'b0, mCollide});
        cmp({tag, "/rlast"}, {24'b0, rLast},     expLast());
        cmp({tag, "/rd0"},   {24'b0, rdatO[0]},  expRead(0));
        cmp({tag, "/rd1"},   {24'b0, rdatO[1]},  expRead(1));
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit w, input bit l,
                                 input int a, input int wdr, input int rd);
        start = s;
        wenR  = w;
        ldr   = l;
        wd    = 3'(a);
        wdatR = 8'(wdr);
        rdat  = 8'(rd);
    endtask

    task automatic setReads(input int a0, input int a1, input logic [1:0] u, input int sel);
        ra[0]  = 3'(a0);
        ra[1]  = 3'(a1);
        useImm = u;
        immSel = 2'(sel);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            tick();
            checkOutput("sweep");
            n++;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{5, 3, 2'b00, 0, 'hA5, 'h22};
        vecs[1] = '{2, 1, 2'b10, 1, 'h10, 67};
        vecs[2] = '{0, 5, 2'b01, 0, 66,   'hA5};
        vecs[3] = '{3, 2, 2'b11, 2, 60,   60};
        vecs[4] = '{7, 4, 2'b11, 3, 0,    0};
        vecs[5] = '{6, 3, 2'b00, 3, 0,    'h22};

        applyStimulus(0, 0, 0, 0, 0, 0);
        setReads(2, 7, 2'b00, 0);
        rstN = 1'b1;
        modelReset();
        #2 rstN = 1'b0;
        #2;
        cmp("resetBusy", {31'b0, busy}, 1);
        cmp("resetColl", {31'b0, wrCollide}, 0);
        cmp("resetReg2", {24'b0, rdatO[0]}, 16);
        checkOutput("reset");
        @(posedge clk);
        #1 rstN = 1'b1;

        // Writes in IDLE must be dropped and raise no collision.
        applyStimulus(0, 1, 1, 0, 'h77, 'h66);
        setReads(0, 7, 2'b00, 0);
        repeat (3) begin
            tick();
            checkOutput("idle");
        end
        cmp("idleReg0", {24'b0, rdatO[0]}, 0);
        cmp("idleColl", {31'b0, wrCollide}, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        // First sweep: exactly NR busy cycles after Start is taken.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start");
        countBusy(n);
        cmp("sweepLen", n, 8);
        for (int i = 0; i < NR; i++) begin
            setReads(i, i, 2'b00, 0);
            #1 cmp("initReg", {24'b0, rdatO[0]}, rv(i));
        end

        // ALU write to reg 5: one-cycle latency unless forwarding is built in.
        applyStimulus(0, 1, 0, 5, 'hA5, 0);
        setReads(5, 5, 2'b00, 0);
        #1;
`ifdef REGFILE_BYPASS_EN
        cmp("sameCycleRead", {24'b0, rdatO[0]}, 'hA5);
`else
        cmp("sameCycleRead", {24'b0, rdatO[0]}, 0);
`endif
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1 cmp("wrLatency", {24'b0, rdatO[0]}, 'hA5);
        checkOutput("wr");

        // Simultaneous ALU and load write: load data wins, single pulse.
        applyStimulus(0, 1, 1, 3, 'h11, 'h22);
        setReads(3, 3, 2'b00, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1;
        cmp("collidePulse", {31'b0, wrCollide}, 1);
        cmp("ldrWins", {24'b0, rdatO[0]}, 'h22);
        checkOutput("coll");
        tick();
        cmp("collideOnce", {31'b0, wrCollide}, 0);
        checkOutput("coll2");

        // Read table against known contents (reg2=16, reg3=0x22, reg5=0xA5).
        for (int v = 0; v < 6; v++) begin
            setReads(vecs[v].ra0, vecs[v].ra1, vecs[v].useI, vecs[v].sel);
            #1;
            cmp("tableRd0", {24'b0, rdatO[0]}, vecs[v].exp0);
            cmp("tableRd1", {24'b0, rdatO[1]}, vecs[v].exp1);
        end

        // Sweep restart at index 4 after reg 7 was set.
        applyStimulus(0, 1, 0, 7, 'h55, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #1 cmp("rLast55", {24'b0, rLast}, 'h55);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("sweepB");
        repeat (4) begin
            tick();
            checkOutput("sweepB");
        end
        cmp("rLastHeld", {24'b0, rLast}, 'h55);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart");
        countBusy(n);
        cmp("restartLen", n, 8);
        cmp("rLastCleared", {24'b0, rLast}, 0);

        // Asynchronous reset in the middle of a sweep.
        applyStimulus(0, 1, 0, 5, 'hA5, 0);
        tick();
        applyStimulus(1, 0, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        tick();
        tick();
        setReads(5, 2, 2'b00, 0);
        #1 cmp("preRstReg5", {24'b0, rdatO[0]}, 'hA5);
        rstN = 1'b0;
        modelReset();
        #2;
        cmp("rstBusy", {31'b0, busy}, 1);
        cmp("rstReg5", {24'b0, rdatO[0]}, 0);
        cmp("rstReg2", {24'b0, rdatO[1]}, 16);
        checkOutput("midReset");
        @(posedge clk);
        #1 rstN = 1'b1;
        applyStimulus(0, 1, 0, 5, 'h3C, 0);
        tick();
        checkOutput("postReset");
        applyStimulus(0, 0, 0, 0, 0, 0);

        // Randomised traffic against the reference model.
        start = 1'b1;
        tick();
        start = 1'b0;
        countBusy(n);
        cmp("randSweepLen", n, 8);
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 7),
                          $urandom_range(0, 255), $urandom_range(0, 255));
            setReads($urandom_range(0, 7), $urandom_range(0, 7),
                     2'($urandom_range(0, 3)), $urandom_range(0, 3));
            #1 checkOutput("rndComb");
            tick();
            checkOutput("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
